// File: rtl/filter_pkg.sv
// filter_pkg: shared state encoding, checksum width and a counter-width helper
// for the filter pixel stream blocks.
`default_nettype none

package filter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int CHECKSUM_WIDTH = 16;

  // A counter over n positions needs at least one bit, even when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// raster_counter: column/row/linear-address tracker for a WIDTH_IMG x HEIGHT_IMG raster.
// Clear has priority over restart, and restart has priority over step.
`default_nettype none

module raster_counter
  import filter_pkg::*;
#(
  parameter int WIDTH_IMG  = 300,
  parameter int HEIGHT_IMG = 300,
  parameter int ADDR_WIDTH = 17,
  parameter int COL_W      = cnt_width(WIDTH_IMG),
  parameter int ROW_W      = cnt_width(HEIGHT_IMG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_restart,
  input  logic                  i_step,
  output logic [COL_W-1:0]      o_col,
  output logic [ROW_W-1:0]      o_row,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_last
);

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(WIDTH_IMG - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(HEIGHT_IMG - 1);

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_col_last;

  assign w_col_last = (r_col == c_COL_LAST);
  assign o_last     = w_col_last && (r_row == c_ROW_LAST);
  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_addr     = r_addr;

  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (i_restart) begin
      // Restart means position 0 was just consumed, so the next beat lands at 1.
      r_col  <= COL_W'(1);
      r_row  <= '0;
      r_addr <= ADDR_WIDTH'(1);
    end else if (i_step) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
      r_addr <= o_last ? '0 : r_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_frame_capture.sv
// pixel_frame_capture: stores one raster frame from a valid/ready pixel stream into frame RAM.
// Optional CAPTURE_CHECKSUM_EN adds a 16-bit per-frame data sum on frame_checksum.
`default_nettype none

module pixel_frame_capture
  import filter_pkg::*;
#(
  parameter int WIDTH_IMG  = 300,
  parameter int HEIGHT_IMG = 300,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      err_sof,
  output logic [CHECKSUM_WIDTH-1:0] frame_checksum
);

  localparam int COL_W = cnt_width(WIDTH_IMG);
  localparam int ROW_W = cnt_width(HEIGHT_IMG);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_zero;
  logic                  w_step;
  logic                  w_restart;
  logic                  w_clear;
  logic                  w_err;
  logic [COL_W-1:0]      w_col;
  logic [ROW_W-1:0]      w_row;
  logic [ADDR_WIDTH-1:0] w_cnt_addr;
  logic                  w_last;

  raster_counter #(
    .WIDTH_IMG  (WIDTH_IMG),
    .HEIGHT_IMG (HEIGHT_IMG),
    .ADDR_WIDTH (ADDR_WIDTH),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_restart (w_restart),
    .i_step    (w_step),
    .o_col     (w_col),
    .o_row     (w_row),
    .o_addr    (w_cnt_addr),
    .o_last    (w_last)
  );

  assign in_ready = (r_state == WAIT_SOF) || (r_state == CAPTURE);
  assign busy     = in_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_zero      = 1'b0;
    w_step      = 1'b0;
    w_restart   = 1'b0;
    w_clear     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clear = 1'b1;
        if (enable) w_state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (w_accept && in_sof) begin
          w_fire      = 1'b1;
          w_zero      = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (w_accept) begin
          w_fire = 1'b1;
          if (in_sof) begin
            // A fresh SOF restarts the frame at address 0 rather than being dropped.
            w_zero    = 1'b1;
            w_restart = 1'b1;
            w_err     = (w_col != '0) || (w_row != '0);
          end else begin
            w_step = 1'b1;
            if (w_last) w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_clear     = 1'b1;
        w_state_nxt = enable ? WAIT_SOF : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err_sof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= w_fire;
      err_sof    <= w_err;
      frame_done <= (r_state == DONE);
      if (w_fire) begin
        wr_addr <= w_zero ? '0 : w_cnt_addr;
        wr_data <= in_data;
      end
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] r_acc;
  logic [CHECKSUM_WIDTH-1:0] r_checksum;
  logic [CHECKSUM_WIDTH-1:0] w_data_ext;

  assign w_data_ext     = CHECKSUM_WIDTH'(in_data);
  assign frame_checksum = r_checksum;

  // No beats are accepted in DONE, so r_acc already holds the complete frame sum there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_acc      <= '0;
      r_checksum <= '0;
    end else begin
      if (w_fire) r_acc <= w_zero ? w_data_ext : r_acc + w_data_ext;
      if (r_state == DONE) r_checksum <= r_acc;
    end
  end
`else
  assign frame_checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pixel_frame_capture.sv
// tb_pixel_frame_capture: directed vector table plus a hand-written mid-frame reset
// sequence for pixel_frame_capture at 4x3 pixels.
`default_nettype none

module tb_pixel_frame_capture;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;
  logic          err_sof;
  logic [15:0]   frame_checksum;

  pixel_frame_capture #(
    .WIDTH_IMG  (W),
    .HEIGHT_IMG (H),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .in_ready       (in_ready),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_sof        (err_sof),
    .frame_checksum (frame_checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic        sof;
    logic [7:0]  d;
    logic        we;
    int          addr;
    logic [7:0]  wd;
    logic        err;
    logic        done;
    logic        bsy;
    logic [15:0] cks;
  } vec_t;

  vec_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic sof, input logic [7:0] d,
                     input logic we, input int addr, input logic [7:0] wd,
                     input logic err, input logic done, input logic bsy, input logic [15:0] cks);
    vec_t t;
    t.en = en; t.v = v; t.sof = sof; t.d = d; t.we = we; t.addr = addr; t.wd = wd;
    t.err = err; t.done = done; t.bsy = bsy; t.cks = cks;
    q.push_back(t);
  endtask

  // Enable from IDLE, then data 1..12 with SOF on the first beat; sum 78.
  task automatic add_basic_frame();
    add(1, 0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 1, 16'd0);
    for (int k = 1; k <= 12; k++)
      add(1, 1, k == 1, 8'(k), 1, k - 1, 8'(k), 0, 0, k != 12, 16'd0);
    add(1, 0, 0, 8'd0, 0, 0, 8'd0, 0, 1, 1, 16'd78);
  endtask

  // Each record: drive inputs at negedge, check registered outputs just after posedge.
  task automatic run_vectors();
    int exp_cks;
    foreach (q[i]) begin
      @(negedge clk);
      enable   = q[i].en;
      in_valid = q[i].v;
      in_sof   = q[i].sof;
      in_data  = q[i].d;
      @(posedge clk);
      #1;
      chk("wr_en", i, int'(wr_en), int'(q[i].we));
      chk("busy", i, int'(busy), int'(q[i].bsy));
      chk("in_ready", i, int'(in_ready), int'(q[i].bsy));
      chk("err_sof", i, int'(err_sof), int'(q[i].err));
      chk("frame_done", i, int'(frame_done), int'(q[i].done));
      if (q[i].we) begin
        chk("wr_addr", i, int'(wr_addr), q[i].addr);
        chk("wr_data", i, int'(wr_data), int'(q[i].wd));
      end
      if (q[i].done) begin
`ifdef CAPTURE_CHECKSUM_EN
        exp_cks = int'(q[i].cks);
`else
        exp_cks = 0;
`endif
        chk("frame_checksum", i, int'(frame_checksum), exp_cks);
      end
    end
    q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset wr_en", -1, int'(wr_en), 0);
    chk("reset busy", -1, int'(busy), 0);
    chk("reset in_ready", -1, int'(in_ready), 0);
    chk("reset frame_done", -1, int'(frame_done), 0);
    chk("reset err_sof", -1, int'(err_sof), 0);
    chk("reset checksum", -1, int'(frame_checksum), 0);
    @(negedge clk);
    rst = 1'b1;

    add_basic_frame();

    // Junk beats in WAIT_SOF are swallowed without writes.
    for (int j = 0; j < 3; j++)
      add(1, 1, 0, 8'h55, 0, 0, 8'd0, 0, 0, 1, 16'd0);
    // Gapped frame of 0xFF with enable dropped: valid pattern 1,0,0,1,...; sum 3060.
    for (int k = 0; k < 12; k++) begin
      add(0, 1, k == 0, 8'hFF, 1, k, 8'hFF, 0, 0, k != 11, 16'd0);
      if (k != 11) begin
        add(0, 0, 0, 8'h00, 0, 0, 8'd0, 0, 0, 1, 16'd0);
        add(0, 0, 1, 8'h11, 0, 0, 8'd0, 0, 0, 1, 16'd0);
      end
    end
    add(0, 0, 0, 8'd0, 0, 0, 8'd0, 0, 1, 0, 16'd3060);
    add(0, 0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0, 16'd0);

    // Mid-frame SOF on beat 6 restarts at address 0; sum 0xAA + 1..11 = 236.
    add(1, 0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 1, 16'd0);
    for (int k = 1; k <= 5; k++)
      add(0, 1, k == 1, 8'(k), 1, k - 1, 8'(k), 0, 0, 1, 16'd0);
    add(0, 1, 1, 8'hAA, 1, 0, 8'hAA, 1, 0, 1, 16'd0);
    for (int k = 1; k <= 11; k++)
      add(0, 1, 0, 8'(k), 1, k, 8'(k), 0, 0, k != 11, 16'd0);
    add(0, 0, 0, 8'd0, 0, 0, 8'd0, 0, 1, 0, 16'd236);
    run_vectors();

    // Reset for one cycle after 5 captured beats abandons the frame.
    @(negedge clk);
    enable = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      enable = 1'b0; in_valid = 1'b1; in_sof = (k == 1); in_data = 8'(8'h40 + k);
    end
    @(negedge clk);
    rst = 1'b0; in_sof = 1'b0; in_data = 8'h99;
    @(posedge clk);
    #1;
    chk("rst busy", -2, int'(busy), 0);
    chk("rst in_ready", -2, int'(in_ready), 0);
    chk("rst wr_en", -2, int'(wr_en), 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("post-rst frame_done", -3, int'(frame_done), 0);
      chk("post-rst busy", -3, int'(busy), 0);
    end

    add_basic_frame();
    run_vectors();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
